// File: rtl/arith_pipe_pkg.sv
// Shared types and default per-stage configuration
// for the arith_pipe elastic arithmetic pipeline.
package arith_pipe_pkg;

   typedef enum logic [1:0] {
      PASS = 2'd0,
      ADD  = 2'd1,
      MUL  = 2'd2
   } op_e;

   localparam int MAX_DEPTH = 8;

   // Entry [0] configures stage 0 (nearest the input).
   localparam op_e DEF_STAGE_OP [MAX_DEPTH] = '{
      ADD, MUL, MUL, MUL, PASS, PASS, PASS, PASS
   };

   localparam int unsigned DEF_STAGE_K [MAX_DEPTH] = '{
      1, 2, 3, 2, 0, 0, 0, 0
   };

endpackage

// File: rtl/arith_stage.sv
// One pipeline slot: constant-operand op unit feeding
// a data/valid register with elastic load logic.
module arith_stage
   import arith_pipe_pkg::*;
#(
   parameter int              WIDTH = 4,
   parameter op_e             OP    = PASS,
   parameter logic [WIDTH-1:0] K    = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  logic             down_load,
   output logic             load,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic [WIDTH-1:0] res;

   // Operation on the upstream word, truncated to WIDTH bits
   always_comb begin
      res = up_data;
      unique case (OP)
         PASS:    res = up_data;
         ADD:     res = up_data + K;
         MUL:     res = up_data * K;
         default: res = up_data;
      endcase
   end

   // An empty slot always loads, so bubbles collapse
   assign load = ~valid | down_load;

   // Slot register; flush drops validity but keeps stale data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= up_valid;
         data  <= res;
      end
   end

endmodule

// File: rtl/arith_pipe.sv
// Elastic valid/ready arithmetic pipeline of DEPTH
// arith_stage slots with flush and occupancy count.
module arith_pipe
   import arith_pipe_pkg::*;
#(
   parameter int          WIDTH    = 4,
   parameter int          DEPTH    = 4,
   parameter op_e         STAGE_OP [MAX_DEPTH] = DEF_STAGE_OP,
   parameter int unsigned STAGE_K  [MAX_DEPTH] = DEF_STAGE_K,
   localparam int         OCC_W    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [OCC_W-1:0] occupancy
);

   logic [DEPTH-1:0] vq;

   for (genvar i = 0; i < DEPTH; i++) begin : g_st
      logic             v;
      logic [WIDTH-1:0] d;
      logic             ld;
      logic             uv;
      logic [WIDTH-1:0] ud;
      logic             dl;

      if (i == 0) begin : g_head
         assign uv = in_valid;
         assign ud = in_data;
      end else begin : g_body
         assign uv = g_st[i-1].v;
         assign ud = g_st[i-1].d;
      end

      if (i == DEPTH - 1) begin : g_tail
         assign dl = out_ready;
      end else begin : g_mid
         assign dl = g_st[i+1].ld;
      end

      arith_stage #(
         .WIDTH (WIDTH),
         .OP    (STAGE_OP[i]),
         .K     (WIDTH'(STAGE_K[i]))
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush),
         .up_valid  (uv),
         .up_data   (ud),
         .down_load (dl),
         .load      (ld),
         .valid     (v),
         .data      (d)
      );

      assign vq[i] = v;
   end

   assign in_ready  = g_st[0].ld & ~flush;
   assign out_valid = g_st[DEPTH-1].v;
   assign out_data  = g_st[DEPTH-1].d;

   // Population count of the slot valid flops
   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupancy = occupancy + OCC_W'(vq[i]);
      end
   end

endmodule

// File: tb/tb_arith_pipe.sv
// Randomised and directed bench for arith_pipe against
// a queue-of-items reference model.
module tb_arith_pipe;
   import arith_pipe_pkg::*;

   localparam int D = 4;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [3:0] out_data;
   logic       out_ready;
   logic [2:0] occupancy;

   logic       flush2;
   logic       in_valid2;
   logic [7:0] in_data2;
   logic       in_ready2;
   logic       out_valid2;
   logic [7:0] out_data2;
   logic       out_ready2;
   logic [1:0] occupancy2;

   int checks;
   int failures;

   typedef struct {
      int unsigned val;
      int          pos;
   } item_t;

   item_t       mq [$];
   int unsigned got [$];

   logic       last_rdy;
   logic       last_ov;
   logic [3:0] last_od;
   int         last_occ;

   arith_pipe u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   arith_pipe #(
      .WIDTH    (8),
      .DEPTH    (2),
      .STAGE_OP ('{ADD, MUL, PASS, PASS, PASS, PASS, PASS, PASS}),
      .STAGE_K  ('{1, 2, 0, 0, 0, 0, 0, 0})
   ) u_wide (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush2),
      .in_valid  (in_valid2),
      .in_data   (in_data2),
      .in_ready  (in_ready2),
      .out_valid (out_valid2),
      .out_data  (out_data2),
      .out_ready (out_ready2),
      .occupancy (occupancy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // x+1, *2, *3, *2, all modulo 16
   function automatic int unsigned ref_f(input int unsigned x);
      int unsigned r;
      r = ((x + 1) % 16);
      r = (r * 2) % 16;
      r = (r * 3) % 16;
      r = (r * 2) % 16;
      return r;
   endfunction

   task automatic drive_cycle(input logic iv, input logic [3:0] id,
                              input logic ordy, input logic fl);
      logic  exp_rdy;
      logic  exp_ov;
      int    lim;
      int    np;
      item_t t;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      exp_rdy = !fl && (mq.size() < D || ordy);
      exp_ov  = mq.size() > 0 && mq[0].pos == D - 1;
      last_rdy = in_ready;
      last_ov  = out_valid;
      last_od  = out_data;
      last_occ = int'(occupancy);
      checks++;
      if (in_ready !== exp_rdy) begin
         failures++;
         $display("FAIL model_in_ready t=%0t got=%b exp=%b",
                  $time, in_ready, exp_rdy);
      end
      checks++;
      if (out_valid !== exp_ov) begin
         failures++;
         $display("FAIL model_out_valid t=%0t got=%b exp=%b",
                  $time, out_valid, exp_ov);
      end
      checks++;
      if (int'(occupancy) != mq.size()) begin
         failures++;
         $display("FAIL model_occupancy t=%0t got=%0d exp=%0d",
                  $time, occupancy, mq.size());
      end
      if (exp_ov) begin
         checks++;
         if (int'(out_data) != mq[0].val) begin
            failures++;
            $display("FAIL model_out_data t=%0t got=%0d exp=%0d",
                     $time, out_data, mq[0].val);
         end
         if (ordy) got.push_back(int'(out_data));
      end
      @(posedge clk);
      if (fl) begin
         mq.delete();
      end else begin
         if (exp_ov && ordy) void'(mq.pop_front());
         lim = D - 1;
         for (int k = 0; k < mq.size(); k++) begin
            t  = mq[k];
            np = t.pos + 1;
            if (np > lim) np = lim;
            t.pos = np;
            mq[k] = t;
            lim = np - 1;
         end
         if (iv && exp_rdy) begin
            t.val = ref_f(int'(id));
            t.pos = 0;
            mq.push_back(t);
         end
      end
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 8; k++) drive_cycle(1'b0, 4'd0, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      flush2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 3'd0 || out_data !== 4'd0) begin
         failures++;
         $display("FAIL reset_state got=%b/%0d/%0d exp=0/0/0",
                  out_valid, occupancy, out_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      int ov_cnt;
      int first;
      got.delete();
      drive_cycle(1'b1, 4'd1, 1'b1, 1'b0);
      ov_cnt = 0;
      first  = -1;
      for (int k = 0; k < 8; k++) begin
         drive_cycle(1'b0, 4'd0, 1'b1, 1'b0);
         if (last_ov) begin
            ov_cnt++;
            if (first < 0) first = k;
         end
      end
      checks++;
      if (ov_cnt != 1 || first != 3) begin
         failures++;
         $display("FAIL single_timing got=cnt%0d@%0d exp=cnt1@3",
                  ov_cnt, first);
      end
      checks++;
      if (got.size() != 1 || got[0] != 8) begin
         failures++;
         $display("FAIL single_value got=n%0d exp=8", got.size());
      end
   endtask

   task automatic test_back_to_back();
      int unsigned exp [4] = '{12, 8, 4, 0};
      logic [5:0]  mask;
      got.delete();
      for (int k = 0; k < 4; k++) begin
         drive_cycle(1'b1, 4'(k), 1'b1, 1'b0);
         checks++;
         if (last_rdy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_in_ready word%0d got=%b exp=1", k, last_rdy);
         end
      end
      mask = '0;
      for (int k = 0; k < 6; k++) begin
         drive_cycle(1'b0, 4'd0, 1'b1, 1'b0);
         mask[k] = last_ov;
      end
      checks++;
      if (mask !== 6'b001111) begin
         failures++;
         $display("FAIL b2b_valid_pattern got=%b exp=001111", mask);
      end
      checks++;
      if (got.size() != 4) begin
         failures++;
         $display("FAIL b2b_count got=%0d exp=4", got.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] != exp[k]) begin
               failures++;
               $display("FAIL b2b_value%0d got=%0d exp=%0d",
                        k, got[k], exp[k]);
            end
         end
      end
   endtask

   task automatic test_stall_fill();
      logic [3:0]  w [4];
      logic [3:0]  held;
      got.delete();
      for (int k = 0; k < 4; k++) begin
         w[k] = 4'($urandom_range(15));
         drive_cycle(1'b1, w[k], 1'b0, 1'b0);
      end
      drive_cycle(1'b1, 4'd5, 1'b0, 1'b0);
      held = last_od;
      checks++;
      if (last_occ != 4 || last_rdy !== 1'b0) begin
         failures++;
         $display("FAIL full_stall got=occ%0d rdy%b exp=occ4 rdy0",
                  last_occ, last_rdy);
      end
      drive_cycle(1'b0, 4'd0, 1'b0, 1'b0);
      drive_cycle(1'b0, 4'd0, 1'b0, 1'b0);
      checks++;
      if (last_od !== held) begin
         failures++;
         $display("FAIL stall_stable got=%0d exp=%0d", last_od, held);
      end
      drain();
      checks++;
      if (got.size() != 4) begin
         failures++;
         $display("FAIL fill_drain_count got=%0d exp=4", got.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] != ref_f(int'(w[k]))) begin
               failures++;
               $display("FAIL fill_drain_value%0d got=%0d exp=%0d",
                        k, got[k], ref_f(int'(w[k])));
            end
         end
      end
   endtask

   task automatic test_bubble();
      got.delete();
      drive_cycle(1'b1, 4'd6, 1'b0, 1'b0);
      drive_cycle(1'b0, 4'd0, 1'b0, 1'b0);
      drive_cycle(1'b1, 4'd9, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) drive_cycle(1'b0, 4'd0, 1'b0, 1'b0);
      checks++;
      if (last_occ != 2 || last_rdy !== 1'b1 || last_ov !== 1'b1) begin
         failures++;
         $display("FAIL bubble_compact got=occ%0d rdy%b ov%b exp=occ2 rdy1 ov1",
                  last_occ, last_rdy, last_ov);
      end
      drain();
      checks++;
      if (got.size() != 2 || got[0] != ref_f(6) || got[1] != ref_f(9)) begin
         failures++;
         $display("FAIL bubble_order got=n%0d exp=%0d,%0d",
                  got.size(), ref_f(6), ref_f(9));
      end
   endtask

   task automatic test_flush();
      got.delete();
      for (int k = 0; k < 3; k++) drive_cycle(1'b1, 4'(k + 3), 1'b0, 1'b0);
      drive_cycle(1'b1, 4'd7, 1'b0, 1'b1);
      checks++;
      if (last_occ != 3 || last_rdy !== 1'b0) begin
         failures++;
         $display("FAIL flush_cycle got=occ%0d rdy%b exp=occ3 rdy0",
                  last_occ, last_rdy);
      end
      drive_cycle(1'b0, 4'd0, 1'b1, 1'b0);
      checks++;
      if (last_occ != 0 || last_ov !== 1'b0) begin
         failures++;
         $display("FAIL flush_after got=occ%0d ov%b exp=occ0 ov0",
                  last_occ, last_ov);
      end
      drain();
      checks++;
      if (got.size() != 0) begin
         failures++;
         $display("FAIL flush_leak got=%0d exp=0", got.size());
      end
   endtask

   task automatic test_async_reset();
      got.delete();
      drive_cycle(1'b1, 4'd2, 1'b0, 1'b0);
      drive_cycle(1'b1, 4'd4, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) drive_cycle(1'b0, 4'd0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 3'd0 || out_data !== 4'd0) begin
         failures++;
         $display("FAIL async_reset got=%b/%0d/%0d exp=0/0/0",
                  out_valid, occupancy, out_data);
      end
      mq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_single();
   endtask

   task automatic test_random();
      logic iv;
      logic ordy;
      logic fl;
      for (int k = 0; k < 400; k++) begin
         iv   = ($urandom_range(3) != 0);
         ordy = ($urandom_range(2) != 0);
         fl   = ($urandom_range(24) == 0);
         drive_cycle(iv, 4'($urandom_range(15)), ordy, fl);
      end
      drain();
   endtask

   task automatic test_wide();
      int first;
      in_valid2 = 1'b1;
      in_data2  = 8'd200;
      @(negedge clk);
      checks++;
      if (in_ready2 !== 1'b1) begin
         failures++;
         $display("FAIL wide_in_ready got=%b exp=1", in_ready2);
      end
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
      first = -1;
      for (int k = 0; k < 10 && first < 0; k++) begin
         @(negedge clk);
         if (out_valid2) first = k;
      end
      checks++;
      if (first != 1) begin
         failures++;
         $display("FAIL wide_latency got=%0d exp=1", first);
      end
      checks++;
      if (out_data2 !== 8'd146) begin
         failures++;
         $display("FAIL wide_value got=%0d exp=146", out_data2);
      end
      @(negedge clk);
      checks++;
      if (out_valid2 !== 1'b0) begin
         failures++;
         $display("FAIL wide_one_shot got=%b exp=0", out_valid2);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_stall_fill();
      test_bubble();
      test_flush();
      test_async_reset();
      test_random();
      test_wide();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
